// File: rtl/square_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the generator divider from start to stop,
// switching only on generator period boundaries, with dwell, loop and abort.
module square_sweep_ctrl #(
  parameter int DIV_W   = 27,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_start,
  input  logic [DIV_W-1:0]   cfg_stop,
  input  logic [DIV_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               abort,
  input  logic               period_end,
  output logic [DIV_W-1:0]   div_out,
  output logic               div_load,
  output logic               busy,
  output logic               done
);

  // state   | meaning
  // S_IDLE  | accepting a configuration, div_out holds last value
  // S_LOAD  | start divider just presented, one cycle
  // S_DWELL | counting generator periods, stepping the divider
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

  localparam logic [DIV_W-1:0]   DIV_ONE = 1;
  localparam logic [DWELL_W-1:0] CNT_ONE = 1;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d, cnt_q, cnt_d;
  logic                 loop_q, loop_d, up_q, up_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 div_load_q, div_load_d;

  logic                 xfer, term, at_stop;
  logic [DIV_W-1:0]     step_eff, div_next;
  logic [DWELL_W-1:0]   dwell_eff;
  logic [DIV_W:0]       sum_w, diff_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      loop_q     <= 1'b0;
      up_q       <= 1'b0;
      cnt_q      <= '0;
      div_q      <= '0;
      div_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      loop_q     <= loop_d;
      up_q       <= up_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      div_load_q <= div_load_d;
    end
  end

  // Zero step/dwell behave as 1; the extra sum/diff bit flags wrap, which clamps to stop.
  always_comb begin
    xfer      = cfg_valid && (state_q == S_IDLE);
    step_eff  = (step_q == '0) ? DIV_ONE : step_q;
    dwell_eff = (dwell_q == '0) ? CNT_ONE : dwell_q;
    term      = period_end && (cnt_q == dwell_eff - CNT_ONE);
    at_stop   = (div_q == stop_q);
    sum_w     = {1'b0, div_q} + {1'b0, step_eff};
    diff_w    = {1'b0, div_q} - {1'b0, step_eff};
    if (up_q)
      div_next = (sum_w[DIV_W] || (sum_w[DIV_W-1:0] > stop_q)) ? stop_q : sum_w[DIV_W-1:0];
    else
      div_next = (diff_w[DIV_W] || (diff_w[DIV_W-1:0] < stop_q)) ? stop_q : diff_w[DIV_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_LOAD;
      S_LOAD:  state_d = abort ? S_IDLE : S_DWELL;
      S_DWELL: begin
        if (abort)                         state_d = S_IDLE;
        else if (term && at_stop && !loop_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d    = start_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    loop_d     = loop_q;
    up_d       = up_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    div_load_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          start_d    = cfg_start;
          stop_d     = cfg_stop;
          step_d     = cfg_step;
          dwell_d    = cfg_dwell;
          loop_d     = cfg_loop;
          up_d       = (cfg_start <= cfg_stop);
          div_d      = cfg_start;
          div_load_d = 1'b1;
          cnt_d      = '0;
        end
      end
      S_LOAD: cnt_d = '0;
      S_DWELL: begin
        if (!abort && period_end) begin
          if (term) begin
            cnt_d = '0;
            if (!at_stop) begin
              div_d      = div_next;
              div_load_d = 1'b1;
            end else if (loop_q) begin
              div_d      = start_q;
              div_load_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_DWELL);
  assign done      = (state_q == S_DONE);
  assign div_out   = div_q;
  assign div_load  = div_load_q;

endmodule

// File: tb/tb_square_sweep_ctrl.sv
// Randomized bench for square_sweep_ctrl: expected divider sequences come from
// a plain-arithmetic model of the sweep rules, checked pulse by pulse.
module tb_square_sweep_ctrl;
  localparam int DIV_W   = 27;
  localparam int DWELL_W = 16;
  localparam longint MAXV = (longint'(1) << DIV_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid, cfg_ready, cfg_loop, abort, period_end;
  logic [DIV_W-1:0]   cfg_start, cfg_stop, cfg_step, div_out;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               div_load, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  longint exp_q[$];

  always #5 clk = ~clk;

  square_sweep_ctrl #(.DIV_W(DIV_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .abort(abort),
    .period_end(period_end), .div_out(div_out), .div_load(div_load),
    .busy(busy), .done(done)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_seq(input longint s, input longint e, input longint st);
    longint v, inc;
    exp_q.delete();
    inc = (st == 0) ? 1 : st;
    v = s;
    exp_q.push_back(v);
    while (v != e) begin
      if (s <= e) v = (v + inc > e) ? e : v + inc;
      else        v = (v - inc < e) ? e : v - inc;
      exp_q.push_back(v);
    end
  endtask

  // mode: 0 run to completion, 1 abort on the terminal pulse of value number
  // stop_at, 2 reset in the first dwell period of value number stop_at.
  task automatic run_sweep(input longint s, input longint e, input longint st,
                           input int dw, input bit lp, input int mode, input int stop_at);
    int n, dwe, idx, vcount, gaps;
    bit last;
    longint cur;
    build_seq(s, e, st);
    n = exp_q.size();
    dwe = (dw == 0) ? 1 : dw;
    cfg_start = DIV_W'(s); cfg_stop = DIV_W'(e); cfg_step = DIV_W'(st);
    cfg_dwell = DWELL_W'(dw); cfg_loop = lp; cfg_valid = 1'b1;
    chk_eq("ready_idle", cfg_ready, 1);
    tick;
    cfg_start = DIV_W'($urandom); cfg_stop = DIV_W'($urandom);
    cfg_step = DIV_W'($urandom); cfg_dwell = DWELL_W'($urandom); cfg_loop = $urandom_range(0, 1);
    cfg_valid = $urandom_range(0, 1);
    chk_eq("load_div", div_out, exp_q[0]);
    chk_eq("load_pulse", div_load, 1);
    chk_eq("load_busy", busy, 1);
    chk_eq("load_ready", cfg_ready, 0);
    period_end = $urandom_range(0, 1);
    tick;
    period_end = 1'b0;
    chk_eq("load_exit_pulse", div_load, 0);
    chk_eq("load_exit_div", div_out, exp_q[0]);
    idx = 0;
    vcount = 0;
    forever begin
      cur = exp_q[idx];
      for (int k = 0; k < dwe; k++) begin
        last = (k == dwe - 1);
        gaps = $urandom_range(0, 2);
        repeat (gaps) begin
          cfg_valid = $urandom_range(0, 1);
          tick;
          chk_eq("gap_pulse", div_load, 0);
          chk_eq("gap_busy", busy, 1);
          chk_eq("gap_div", div_out, cur);
        end
        cfg_valid = 1'b0;
        if (mode == 2 && vcount == stop_at && k == 0) begin
          rst = 1'b0;
          tick;
          rst = 1'b1;
          chk_eq("rst_div", div_out, 0);
          chk_eq("rst_busy", busy, 0);
          chk_eq("rst_ready", cfg_ready, 1);
          chk_eq("rst_done", done, 0);
          chk_eq("rst_pulse", div_load, 0);
          return;
        end
        if (mode == 1 && vcount == stop_at && last) begin
          abort = 1'b1; period_end = 1'b1;
          tick;
          abort = 1'b0; period_end = 1'b0;
          chk_eq("abort_busy", busy, 0);
          chk_eq("abort_ready", cfg_ready, 1);
          chk_eq("abort_pulse", div_load, 0);
          chk_eq("abort_done", done, 0);
          chk_eq("abort_div", div_out, cur);
          tick;
          chk_eq("abort_idle_done", done, 0);
          return;
        end
        period_end = 1'b1;
        tick;
        period_end = 1'b0;
        if (!last) begin
          chk_eq("dwell_pulse", div_load, 0);
          chk_eq("dwell_div", div_out, cur);
          chk_eq("dwell_done", done, 0);
        end
      end
      vcount++;
      if (idx == n - 1 && !lp) begin
        chk_eq("done_pulse", done, 1);
        chk_eq("done_busy", busy, 0);
        chk_eq("done_load", div_load, 0);
        chk_eq("done_div", div_out, cur);
        tick;
        chk_eq("done_clear", done, 0);
        chk_eq("done_ready", cfg_ready, 1);
        chk_eq("done_hold_div", div_out, cur);
        return;
      end
      idx = (idx == n - 1) ? 0 : idx + 1;
      chk_eq("step_pulse", div_load, 1);
      chk_eq("step_div", div_out, exp_q[idx]);
      chk_eq("step_busy", busy, 1);
      if (vcount > 4000) begin
        chk_eq("sweep_bound", vcount, 0);
        return;
      end
    end
  endtask

  initial begin
    longint s, e, st;
    int d, mode;
    bit lp;
    rst = 1'b0; cfg_valid = 1'b0; cfg_loop = 1'b0; abort = 1'b0; period_end = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0;
    tick;
    chk_eq("reset_ready", cfg_ready, 1);
    chk_eq("reset_busy", busy, 0);
    chk_eq("reset_done", done, 0);
    chk_eq("reset_load", div_load, 0);
    chk_eq("reset_div", div_out, 0);
    rst = 1'b1;
    period_end = 1'b1;
    tick;
    period_end = 1'b0;
    chk_eq("idle_pe_ignored", busy, 0);

    run_sweep(100, 130, 10, 2, 0, 0, 0);
    run_sweep(100, 125, 10, 1, 0, 0, 0);
    run_sweep(50, 20, 15, 3, 0, 0, 0);
    run_sweep(MAXV - 4, MAXV, 10, 2, 0, 0, 0);
    run_sweep(40, 40, 0, 0, 0, 0, 0);
    run_sweep(10, 12, 1, 1, 1, 1, 7);
    run_sweep(100, 200, 5, 2, 0, 2, 3);
    run_sweep(100, 130, 10, 2, 0, 0, 0);
    run_sweep(30, 0, 7, 1, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      s = $urandom_range(0, 32'(MAXV));
      if ($urandom_range(0, 3) == 0) s = MAXV - $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 40);
      d = $urandom_range(0, 120);
      if ($urandom_range(0, 1) == 1) e = (s + d > MAXV) ? MAXV : s + d;
      else                           e = (s - d < 0) ? 0 : s - d;
      st = $urandom_range(0, 40);
      lp = $urandom_range(0, 1);
      mode = lp ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      run_sweep(s, e, st, $urandom_range(0, 3), lp, mode, $urandom_range(0, 12));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
